// File: rtl/guess_pkg.sv
// Shared types for the guessing-game engine: FSM state encoding and compare flags.
package guess_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } guess_state_t;

  typedef struct packed {
    logic over;
    logic under;
    logic equal;
  } cmp_t;

endpackage

// File: rtl/guess_seed_counter.sv
// Free-running wrap-around counter; its value is sampled as the round secret.
module guess_seed_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] seed
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) seed <= '0;
    else       seed <= seed + WIDTH'(1);
  end

endmodule

// File: rtl/guess_engine.sv
// Guessing-game round engine: secret capture, guess compare, attempt count and best score.
module guess_engine
  import guess_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MAX_GUESSES = 7,
  parameter int RW          = $clog2(MAX_GUESSES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_guess_valid,
  input  logic [WIDTH-1:0] i_guess,
  output logic             o_result_valid,
  output logic             o_over,
  output logic             o_under,
  output logic             o_equal,
  output logic [RW-1:0]    o_remain,
  output logic             o_playing,
  output logic             o_win,
  output logic             o_lose,
  output logic [RW-1:0]    o_best
);

  localparam logic [RW-1:0] MAX_R = RW'(MAX_GUESSES);

  guess_state_t     state, state_nxt;
  logic [WIDTH-1:0] seed, secret;
  cmp_t             flags, cmp;
  logic [RW-1:0]    remain, best, used;
  logic             result_vld;
  logic             guess_acc;

  guess_seed_counter #(.WIDTH(WIDTH)) u_seed (
    .clk   (clk),
    .reset (reset),
    .seed  (seed)
  );

  // Start has priority: a strobe coinciding with a restart is dropped.
  assign guess_acc = (state == PLAY) && i_guess_valid && !i_start;

  always_comb begin
    cmp.over  = (i_guess > secret);
    cmp.under = (i_guess < secret);
    cmp.equal = (i_guess == secret);
  end

  // Attempts used once this guess is counted (remain is pre-decrement here).
  assign used = MAX_R - (remain - RW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_start) begin
      state_nxt = PLAY;
    end else if (guess_acc) begin
      if (cmp.equal)               state_nxt = WIN;
      else if (remain == RW'(1))   state_nxt = LOSE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      secret     <= '0;
      remain     <= MAX_R;
      flags      <= '0;
      result_vld <= 1'b0;
      best       <= '0;
    end else begin
      result_vld <= guess_acc;
      if (i_start) begin
        secret <= seed;
        remain <= MAX_R;
        flags  <= '0;
      end else if (guess_acc) begin
        flags  <= cmp;
        remain <= remain - RW'(1);
        if (cmp.equal && (best == '0 || used < best)) best <= used;
      end
    end
  end

  assign o_result_valid = result_vld;
  assign o_over         = flags.over;
  assign o_under        = flags.under;
  assign o_equal        = flags.equal;
  assign o_remain       = remain;
  assign o_best         = best;
  assign o_playing      = (state == PLAY);
  assign o_win          = (state == WIN);
  assign o_lose         = (state == LOSE);

endmodule

// File: tb/tb_guess_engine.sv
// Bench for guess_engine: directed scenarios plus random play against a round-level model.
module tb_guess_engine;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // dut0: default parameters
  logic       st0, gv0;
  logic [7:0] g0;
  logic       rv0, ov0, un0, eq0, pl0, wn0, ls0;
  logic [2:0] rem0, best0;
  // dut1: WIDTH=4, MAX_GUESSES=3
  logic       st1, gv1;
  logic [3:0] g1;
  logic       rv1, ov1, un1, eq1, pl1, wn1, ls1;
  logic [1:0] rem1, best1;

  guess_engine dut0 (
    .clk(clk), .reset(reset), .i_start(st0), .i_guess_valid(gv0), .i_guess(g0),
    .o_result_valid(rv0), .o_over(ov0), .o_under(un0), .o_equal(eq0),
    .o_remain(rem0), .o_playing(pl0), .o_win(wn0), .o_lose(ls0), .o_best(best0)
  );

  guess_engine #(.WIDTH(4), .MAX_GUESSES(3)) dut1 (
    .clk(clk), .reset(reset), .i_start(st1), .i_guess_valid(gv1), .i_guess(g1),
    .o_result_valid(rv1), .o_over(ov1), .o_under(un1), .o_equal(eq1),
    .o_remain(rem1), .o_playing(pl1), .o_win(wn1), .o_lose(ls1), .o_best(best1)
  );

  int checks = 0;
  int failures = 0;

  // Cycles since reset release; equals the seed (mod 2^WIDTH) sampled at the next edge.
  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  localparam int S_IDLE = 0, S_PLAY = 1, S_WIN = 2, S_LOSE = 3;
  int wid[2] = '{8, 4};
  int mx[2]  = '{7, 3};
  int m_state[2], m_secret[2], m_remain[2], m_best[2];
  bit m_rv[2], m_ov[2], m_un[2], m_eq[2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = S_IDLE; m_secret[d] = 0; m_remain[d] = mx[d]; m_best[d] = 0;
      m_rv[d] = 0; m_ov[d] = 0; m_un[d] = 0; m_eq[d] = 0;
    end
  endtask

  task automatic model_edge(input int d, input bit s, input bit v, input int g);
    int seed, used;
    seed = cyc % (1 << wid[d]);
    m_rv[d] = 0;
    if (s) begin
      m_secret[d] = seed; m_remain[d] = mx[d]; m_state[d] = S_PLAY;
      m_ov[d] = 0; m_un[d] = 0; m_eq[d] = 0;
    end else if (v && m_state[d] == S_PLAY) begin
      m_ov[d] = g > m_secret[d]; m_un[d] = g < m_secret[d]; m_eq[d] = g == m_secret[d];
      m_rv[d] = 1;
      m_remain[d] = m_remain[d] - 1;
      if (m_eq[d]) begin
        m_state[d] = S_WIN;
        used = mx[d] - m_remain[d];
        if (m_best[d] == 0 || used < m_best[d]) m_best[d] = used;
      end else if (m_remain[d] == 0) m_state[d] = S_LOSE;
    end
  endtask

  task automatic step(input bit s0, input bit v0, input int gg0,
                      input bit s1, input bit v1, input int gg1);
    st0 = s0; gv0 = v0; g0 = gg0[7:0];
    st1 = s1; gv1 = v1; g1 = gg1[3:0];
    model_edge(0, s0, v0, gg0 % 256);
    model_edge(1, s1, v1, gg1 % 16);
    @(posedge clk); #1;
  endtask

  task automatic step0(input bit s, input bit v, input int g);
    step(s, v, g, 1'b0, 1'b0, 0);
  endtask

  task automatic step1(input bit s, input bit v, input int g);
    step(1'b0, 1'b0, 0, s, v, g);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    st0 = 0; gv0 = 0; g0 = '0; st1 = 0; gv1 = 0; g1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rem0 !== 3'd7) begin failures++; $display("FAIL reset_remain0 got=%0d want=7", rem0); end
    checks++; if (rem1 !== 2'd3) begin failures++; $display("FAIL reset_remain1 got=%0d want=3", rem1); end
    checks++; if ({rv0, ov0, un0, eq0} !== 4'b0) begin failures++; $display("FAIL reset_flags0 got=%b want=0000", {rv0, ov0, un0, eq0}); end
    checks++; if ({pl0, wn0, ls0} !== 3'b0) begin failures++; $display("FAIL reset_state0 got=%b want=000", {pl0, wn0, ls0}); end
    checks++; if (best0 !== 3'd0) begin failures++; $display("FAIL reset_best0 got=%0d want=0", best0); end
    checks++; if ({rv1, ov1, un1, eq1, pl1, wn1, ls1, best1} !== 9'b0) begin failures++; $display("FAIL reset_misc1 got=%b want=0", {rv1, ov1, un1, eq1, pl1, wn1, ls1, best1}); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_seed0(input int target);
    for (int i = 0; i < 300 && (cyc % 256) != target; i++) step0(0, 0, 0);
    checks++; if ((cyc % 256) != target) begin failures++; $display("FAIL seed_wait got=%0d want=%0d", cyc % 256, target); end
  endtask

  task automatic test_basic();
    wait_seed0(42);
    step0(1, 0, 0);
    checks++; if (pl0 !== 1'b1 || rem0 !== 3'd7) begin failures++; $display("FAIL start_play got=%b/%0d want=1/7", pl0, rem0); end
    step0(0, 1, 'h10);
    checks++; if ({rv0, ov0, un0, eq0} !== 4'b1010) begin failures++; $display("FAIL guess_under got=%b want=1010", {rv0, ov0, un0, eq0}); end
    checks++; if (rem0 !== 3'd6) begin failures++; $display("FAIL guess_remain got=%0d want=6", rem0); end
    step0(0, 1, 'h2A);
    checks++; if ({rv0, ov0, un0, eq0, wn0} !== 5'b10011) begin failures++; $display("FAIL guess_win got=%b want=10011", {rv0, ov0, un0, eq0, wn0}); end
    checks++; if (rem0 !== 3'd5 || best0 !== 3'd2) begin failures++; $display("FAIL win_score got=%0d/%0d want=5/2", rem0, best0); end
    step0(0, 0, 0);
    checks++; if (rv0 !== 1'b0 || wn0 !== 1'b1) begin failures++; $display("FAIL pulse_width got=%b/%b want=0/1", rv0, wn0); end
  endtask

  task automatic test_back_to_back_lose();
    wait_seed0(42);
    step0(1, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      step0(0, 1, 0);
      checks++;
      if (rv0 !== 1'b1 || un0 !== 1'b1 || rem0 !== 3'(7 - i)) begin
        failures++; $display("FAIL lose_step%0d got=rv%b un%b rem%0d want=rv1 un1 rem%0d", i, rv0, un0, rem0, 7 - i);
      end
    end
    checks++; if (ls0 !== 1'b1 || pl0 !== 1'b0) begin failures++; $display("FAIL lose_state got=%b/%b want=1/0", ls0, pl0); end
    step0(0, 1, 0);
    checks++; if (rv0 !== 1'b0 || rem0 !== 3'd0 || ls0 !== 1'b1) begin failures++; $display("FAIL after_lose got=%b/%0d/%b want=0/0/1", rv0, rem0, ls0); end
  endtask

  task automatic test_best();
    int sec;
    step0(1, 0, 0);
    sec = m_secret[0];
    for (int i = 0; i < 3; i++) step0(0, 1, sec ^ 1);
    step0(0, 1, sec);
    checks++; if (wn0 !== 1'b1 || best0 !== 3'd2 || rem0 !== 3'd3) begin failures++; $display("FAIL best_keep got=%b/%0d/%0d want=1/2/3", wn0, best0, rem0); end
    step0(1, 0, 0);
    sec = m_secret[0];
    step0(0, 1, sec);
    checks++; if (wn0 !== 1'b1 || best0 !== 3'd1 || rem0 !== 3'd6) begin failures++; $display("FAIL best_new got=%b/%0d/%0d want=1/1/6", wn0, best0, rem0); end
  endtask

  task automatic test_start_and_guess();
    int sd;
    step0(1, 0, 0);
    step0(0, 1, m_secret[0] ^ 1);
    sd = cyc % 256;
    step0(1, 1, sd ^ 8'h55);
    checks++; if (rv0 !== 1'b0 || rem0 !== 3'd7 || pl0 !== 1'b1 || {ov0, un0, eq0} !== 3'b0) begin
      failures++; $display("FAIL restart_drop got=rv%b rem%0d pl%b f%b want=rv0 rem7 pl1 f000", rv0, rem0, pl0, {ov0, un0, eq0});
    end
    step0(0, 1, sd);
    checks++; if (eq0 !== 1'b1 || wn0 !== 1'b1) begin failures++; $display("FAIL restart_secret got=%b/%b want=1/1", eq0, wn0); end
  endtask

  task automatic test_small();
    for (int i = 0; i < 20 && (cyc % 16) != 15; i++) step1(0, 0, 0);
    step1(0, 0, 0);
    step1(1, 0, 0);
    step1(0, 1, 15);
    checks++; if ({rv1, ov1, un1, eq1} !== 4'b1100 || rem1 !== 2'd2) begin failures++; $display("FAIL small_over got=%b/%0d want=1100/2", {rv1, ov1, un1, eq1}, rem1); end
    step1(0, 1, 0);
    checks++; if (eq1 !== 1'b1 || wn1 !== 1'b1 || best1 !== 2'd2) begin failures++; $display("FAIL small_wrap_secret got=%b/%b/%0d want=1/1/2", eq1, wn1, best1); end
    step1(1, 0, 0);
    for (int i = 0; i < 3; i++) step1(0, 1, m_secret[1] ^ 1);
    checks++; if (rem1 !== 2'd0 || ls1 !== 1'b1) begin failures++; $display("FAIL small_lose got=%0d/%b want=0/1", rem1, ls1); end
  endtask

  task automatic test_async_reset();
    step0(1, 0, 0);
    step0(0, 1, m_secret[0] ^ 1);
    #2 reset = 1'b1;
    #1;
    checks++; if ({rv0, ov0, un0, eq0, pl0, wn0, ls0} !== 7'b0 || rem0 !== 3'd7 || best0 !== 3'd0) begin
      failures++; $display("FAIL async_reset got=%b rem%0d best%0d want=0 rem7 best0", {rv0, ov0, un0, eq0, pl0, wn0, ls0}, rem0, best0);
    end
    #1 reset = 1'b0;
    model_reset();
    step0(0, 1, 0);
    step0(0, 1, 1);
    checks++; if (rv0 !== 1'b0 || pl0 !== 1'b0 || rem0 !== 3'd7) begin failures++; $display("FAIL ignore_idle got=%b/%b/%0d want=0/0/7", rv0, pl0, rem0); end
  endtask

  task automatic test_random();
    logic [12:0] e0, a0;
    logic [10:0] e1, a1;
    int x0, x1;
    for (int i = 0; i < 400; i++) begin
      x0 = ($urandom_range(0, 3) == 0) ? m_secret[0] : int'($urandom_range(0, 255));
      x1 = ($urandom_range(0, 3) == 0) ? m_secret[1] : int'($urandom_range(0, 15));
      step($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, x0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, x1);
      e0 = {m_rv[0], m_ov[0], m_un[0], m_eq[0], 3'(m_remain[0]),
            m_state[0] == S_PLAY, m_state[0] == S_WIN, m_state[0] == S_LOSE, 3'(m_best[0])};
      a0 = {rv0, ov0, un0, eq0, rem0, pl0, wn0, ls0, best0};
      checks++; if (a0 !== e0) begin failures++; $display("FAIL rand0 step%0d got=%b want=%b", i, a0, e0); end
      e1 = {m_rv[1], m_ov[1], m_un[1], m_eq[1], 2'(m_remain[1]),
            m_state[1] == S_PLAY, m_state[1] == S_WIN, m_state[1] == S_LOSE, 2'(m_best[1])};
      a1 = {rv1, ov1, un1, eq1, rem1, pl1, wn1, ls1, best1};
      checks++; if (a1 !== e1) begin failures++; $display("FAIL rand1 step%0d got=%b want=%b", i, a1, e1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back_lose();
    test_best();
    test_start_and_guess();
    test_small();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
